// File: rtl/l15_mem_responder_pkg.sv
// Shared L1.5 interface encodings and helpers for the memory responder.
package l15_mem_responder_pkg;

  // Request types
  localparam logic [4:0] L15_RQ_LOAD  = 5'b00000;
  localparam logic [4:0] L15_RQ_STORE = 5'b00001;
  localparam logic [4:0] L15_RQ_IMISS = 5'b10000;

  // Return types
  localparam logic [3:0] L15_RET_LOAD   = 4'h0;
  localparam logic [3:0] L15_RET_IFILL  = 4'h1;
  localparam logic [3:0] L15_RET_ST_ACK = 4'h4;

  // Store sizes
  localparam logic [2:0] L15_SIZE_1B = 3'd0;
  localparam logic [2:0] L15_SIZE_2B = 3'd1;
  localparam logic [2:0] L15_SIZE_4B = 3'd2;
  localparam logic [2:0] L15_SIZE_8B = 3'd3;

  // Reverse byte order of a 64-bit word (big-endian bus <-> little-endian store)
  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
    return r;
  endfunction

  function automatic logic rq_supported(input logic [4:0] rq);
    return (rq == L15_RQ_LOAD) || (rq == L15_RQ_STORE) || (rq == L15_RQ_IMISS);
  endfunction

endpackage

// File: rtl/l15_req_fifo.sv
// Request queue for the L1.5 memory responder; caller never pushes when full
// nor pops when empty.
module l15_req_fifo #(
  parameter int Depth    = 2,
  parameter int TidWidth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [4:0]                   rqtype_i,
  input  logic [2:0]                   size_i,
  input  logic [TidWidth-1:0]          tid_i,
  input  logic [39:0]                  addr_i,
  input  logic [63:0]                  data_i,
  input  logic                         pop_i,
  output logic [4:0]                   rqtype_o,
  output logic [2:0]                   size_o,
  output logic [TidWidth-1:0]          tid_o,
  output logic [39:0]                  addr_o,
  output logic [63:0]                  data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         empty_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [4:0]          rqtype;
    logic [2:0]          size;
    logic [TidWidth-1:0] tid;
    logic [39:0]         addr;
    logic [63:0]         data;
  } entry_t;

  entry_t              mem_q [Depth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q;
  entry_t              head;

  // Entry storage; contents need no reset, occupancy is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= '{rqtype_i, size_i, tid_i, addr_i, data_i};
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= (wptr_q == PtrW'(Depth-1)) ? '0 : wptr_q + 1'b1;
      if (pop_i)  rptr_q <= (rptr_q == PtrW'(Depth-1)) ? '0 : rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head     = mem_q[rptr_q];
  assign rqtype_o = head.rqtype;
  assign size_o   = head.size;
  assign tid_o    = head.tid;
  assign addr_o   = head.addr;
  assign data_o   = head.data;
  assign count_o  = count_q;
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/l15_mem_responder.sv
// L1.5 memory responder: queues requests from the cache adapter, serves them
// one at a time from a 128-bit-line backing store after a fixed latency.
module l15_mem_responder
  import l15_mem_responder_pkg::*;
#(
  parameter int NumLines    = 256,
  parameter int RespLatency = 2,
  parameter int FifoDepth   = 2,
  parameter int TidWidth    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                l15_val_i,
  input  logic [4:0]          l15_rqtype_i,
  input  logic [2:0]          l15_size_i,
  input  logic [TidWidth-1:0] l15_threadid_i,
  input  logic [39:0]         l15_address_i,
  input  logic [63:0]         l15_data_i,
  output logic                l15_header_ack_o,
  output logic                l15_val_o,
  input  logic                l15_req_ack_i,
  output logic [3:0]          l15_returntype_o,
  output logic [TidWidth-1:0] l15_threadid_o,
  output logic [63:0]         l15_data_0_o,
  output logic [63:0]         l15_data_1_o
);
  localparam int IdxW = $clog2(NumLines);
  localparam int CntW = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [1:0][63:0]    mem [NumLines];

  logic [4:0]          hd_rqtype;
  logic [2:0]          hd_size;
  logic [TidWidth-1:0] hd_tid;
  logic [39:0]         hd_addr;
  logic [63:0]         hd_data;
  logic [CntW-1:0]     fifo_count;
  logic                fifo_empty, q_full, pop;
  logic [CntW:0]       occ;

  logic [4:0]          cur_rqtype;
  logic [2:0]          cur_size;
  logic [TidWidth-1:0] cur_tid;
  logic [IdxW+3:0]     cur_addr;
  logic [63:0]         cur_data;
  logic [IdxW-1:0]     line_idx;
  logic                commit_st;
  logic [2:0]          st_off;
  logic [7:0]          st_be;
  logic [63:0]         st_wdata;
  logic                unused_addr_hi;

  // The in-flight request keeps its slot, so at most FifoDepth requests are
  // outstanding; the decision uses registered state only.
  assign occ              = {1'b0, fifo_count} + {{CntW{1'b0}}, (state_q != S_IDLE)};
  assign q_full           = occ >= (CntW+1)'(FifoDepth);
  assign l15_header_ack_o = l15_val_i & ~q_full;
  assign pop              = (state_q == S_IDLE) && !fifo_empty;

  l15_req_fifo #(.Depth(FifoDepth), .TidWidth(TidWidth)) u_req_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (l15_header_ack_o),
    .rqtype_i (l15_rqtype_i),
    .size_i   (l15_size_i),
    .tid_i    (l15_threadid_i),
    .addr_i   (l15_address_i),
    .data_i   (l15_data_i),
    .pop_i    (pop),
    .rqtype_o (hd_rqtype),
    .size_o   (hd_size),
    .tid_o    (hd_tid),
    .addr_o   (hd_addr),
    .data_o   (hd_data),
    .count_o  (fifo_count),
    .empty_o  (fifo_empty)
  );

  // Address bits above the line index alias onto the same lines
  assign unused_addr_hi = ^hd_addr[39:IdxW+4];

  // Capture the dequeued request for the duration of its service
  always_ff @(posedge clk_i) begin
    if (pop) begin
      cur_rqtype <= hd_rqtype;
      cur_size   <= hd_size;
      cur_tid    <= hd_tid;
      cur_addr   <= hd_addr[IdxW+3:0];
      cur_data   <= hd_data;
    end
  end

  assign line_idx  = cur_addr[IdxW+3:4];
  assign commit_st = (state_q == S_WAIT) && (cnt_q == '0) && (cur_rqtype == L15_RQ_STORE);

  // Store byte lanes: MSB-first bytes of the bus data land at the size-aligned offset
  always_comb begin
    st_off = '0;
    st_be  = 8'hFF;
    case (cur_size)
      L15_SIZE_1B: begin st_be = 8'h01; st_off = cur_addr[2:0];         end
      L15_SIZE_2B: begin st_be = 8'h03; st_off = {cur_addr[2:1], 1'b0}; end
      L15_SIZE_4B: begin st_be = 8'h0F; st_off = {cur_addr[2], 2'b00};  end
      default:     begin st_be = 8'hFF; st_off = 3'd0;                  end
    endcase
    st_be    = st_be << st_off;
    st_wdata = bswap64(cur_data) << {st_off, 3'b000};
  end

  // Backing store write; not reset, and a reset edge suppresses the commit
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit_st) begin
      for (int b = 0; b < 8; b++)
        if (st_be[b]) mem[line_idx][cur_addr[3]][8*b +: 8] <= st_wdata[8*b +: 8];
    end
  end

  // Service FSM with registered response outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      l15_val_o        <= 1'b0;
      l15_returntype_o <= '0;
      l15_threadid_o   <= '0;
      l15_data_0_o     <= '0;
      l15_data_1_o     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Unsupported requests are popped here and produce nothing
          if (pop && rq_supported(hd_rqtype)) begin
            state_q <= S_WAIT;
            cnt_q   <= 4'(RespLatency - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q        <= S_RESP;
            l15_val_o      <= 1'b1;
            l15_threadid_o <= cur_tid;
            if (cur_rqtype == L15_RQ_STORE) begin
              l15_returntype_o <= L15_RET_ST_ACK;
              l15_data_0_o     <= '0;
              l15_data_1_o     <= '0;
            end else begin
              l15_returntype_o <= (cur_rqtype == L15_RQ_IMISS) ? L15_RET_IFILL : L15_RET_LOAD;
              l15_data_0_o     <= bswap64(mem[line_idx][0]);
              l15_data_1_o     <= bswap64(mem[line_idx][1]);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (l15_req_ack_i) begin
            state_q          <= S_IDLE;
            l15_val_o        <= 1'b0;
            l15_returntype_o <= '0;
            l15_threadid_o   <= '0;
            l15_data_0_o     <= '0;
            l15_data_1_o     <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l15_mem_responder.sv
// Self-checking bench for l15_mem_responder: directed scenarios plus a
// randomized run against a byte-addressed big-endian memory model.
module tb_l15_mem_responder;
  localparam int NL = 256, LAT = 2, DEPTH = 2, TW = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          l15_val_i, l15_req_ack_i;
  logic [4:0]    l15_rqtype_i;
  logic [2:0]    l15_size_i;
  logic [TW-1:0] l15_threadid_i;
  logic [39:0]   l15_address_i;
  logic [63:0]   l15_data_i;
  logic          l15_header_ack_o, l15_val_o;
  logic [3:0]    l15_returntype_o;
  logic [TW-1:0] l15_threadid_o;
  logic [63:0]   l15_data_0_o, l15_data_1_o;

  always #5 clk = ~clk;

  l15_mem_responder #(.NumLines(NL), .RespLatency(LAT), .FifoDepth(DEPTH), .TidWidth(TW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .l15_val_i(l15_val_i), .l15_rqtype_i(l15_rqtype_i),
    .l15_size_i(l15_size_i), .l15_threadid_i(l15_threadid_i), .l15_address_i(l15_address_i),
    .l15_data_i(l15_data_i), .l15_header_ack_o(l15_header_ack_o), .l15_val_o(l15_val_o),
    .l15_req_ack_i(l15_req_ack_i), .l15_returntype_o(l15_returntype_o),
    .l15_threadid_o(l15_threadid_o), .l15_data_0_o(l15_data_0_o), .l15_data_1_o(l15_data_1_o)
  );

  typedef struct packed {
    logic [3:0]    rt;
    logic [TW-1:0] tid;
    logic [63:0]   d0;
    logic [63:0]   d1;
  } exp_t;

  int         n_tests = 0, n_fail = 0;
  logic [7:0] mb [NL*16];      // memory model: byte address -> byte
  logic [7:0] mb_save [NL*16];
  exp_t       expq [$];

  function automatic exp_t cur_out();
    return {l15_returntype_o, l15_threadid_o, l15_data_0_o, l15_data_1_o};
  endfunction

  // Model: apply a request in acceptance order and queue its expected response
  task automatic model_req(input logic [4:0] rq, input logic [2:0] sz, input logic [TW-1:0] tid,
                           input logic [39:0] a, input logic [63:0] d);
    int line, base, n, off;
    exp_t e;
    line = int'((a >> 4) % NL);
    base = line*16 + (a[3] ? 8 : 0);
    e.tid = tid; e.d0 = '0; e.d1 = '0; e.rt = '0;
    if (rq == 5'b00000 || rq == 5'b10000) begin
      e.rt = (rq == 5'b10000) ? 4'h1 : 4'h0;
      for (int i = 0; i < 8; i++) begin
        e.d0 = {e.d0[55:0], mb[line*16 + i]};
        e.d1 = {e.d1[55:0], mb[line*16 + 8 + i]};
      end
      expq.push_back(e);
    end else if (rq == 5'b00001) begin
      n   = 1 << sz;
      off = (int'(a[2:0]) / n) * n;
      for (int j = 0; j < n; j++) mb[base + off + j] = d[63-8*j -: 8];
      e.rt = 4'h4;
      expq.push_back(e);
    end
  endtask

  task automatic preload();
    for (int l = 0; l < NL; l++)
      for (int b = 0; b < 16; b++)
        dut.mem[l][b/8][8*(b%8) +: 8] = mb[l*16 + b];
  endtask

  // Drive one request until header-acked (bounded); returns at accept edge + 1
  task automatic send(input logic [4:0] rq, input logic [2:0] sz, input logic [TW-1:0] tid,
                      input logic [39:0] a, input logic [63:0] d, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      l15_val_i = 1; l15_rqtype_i = rq; l15_size_i = sz; l15_threadid_i = tid;
      l15_address_i = a; l15_data_i = d;
      #1;
      if (l15_header_ack_o) begin
        model_req(rq, sz, tid, a, d);
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    l15_val_i = 0;
  endtask

  // Wait (bounded) for a response; 'waited' counts negedges sampled
  task automatic get_resp(output bit got, output int waited);
    got = 0; waited = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      waited++;
      if (l15_val_o) begin got = 1; break; end
    end
  endtask

  task automatic ack_resp();
    l15_req_ack_i = 1;
    @(posedge clk); #1;
    l15_req_ack_i = 0;
    if (expq.size() != 0) void'(expq.pop_front());
  endtask

  task automatic test_reset();
    rst_ni = 0; l15_val_i = 1; l15_req_ack_i = 0; l15_rqtype_i = 5'b00000;
    l15_size_i = 0; l15_threadid_i = 1; l15_address_i = '0; l15_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({l15_val_o, cur_out()} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {l15_val_o, cur_out()});
    end
    n_tests++;
    if (l15_header_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_queue_empty: header_ack %b want 1", l15_header_ack_o);
    end
    l15_val_i = 0; rst_ni = 1;
    begin
      bit seen = 0;
      repeat (10) begin @(negedge clk); if (l15_val_o !== 1'b0) seen = 1; end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL reset_no_resp: val_o seen=1 want 0"); end
    end
  endtask

  task automatic test_load_basic();
    bit ok, got; int w;
    send(5'b00000, 3'd0, 2'd1, 40'h0, 64'h0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL load_hdr_ack: ok=%b want 1", ok); end
    get_resp(got, w);
    n_tests++;
    if (!got || w != LAT + 2) begin
      n_fail++; $display("FAIL load_latency: got=%b waited=%0d want %0d", got, w, LAT + 2);
    end
    n_tests++;
    if (cur_out() !== expq[0]) begin
      n_fail++; $display("FAIL load_resp: got %h want %h", cur_out(), expq[0]);
    end
    n_tests++;
    if (l15_data_0_o !== 64'h0001020304050607 || l15_returntype_o !== 4'h0 || l15_threadid_o !== 2'd1) begin
      n_fail++; $display("FAIL load_line0: got rt=%h tid=%0d d0=%h want 0/1/0001020304050607",
                         l15_returntype_o, l15_threadid_o, l15_data_0_o);
    end
    // held without ack: response must stay put
    repeat (3) @(negedge clk);
    n_tests++;
    if (!l15_val_o || cur_out() !== expq[0]) begin
      n_fail++; $display("FAIL load_hold: val=%b got %h want %h", l15_val_o, cur_out(), expq[0]);
    end
    ack_resp();
    @(negedge clk);
    n_tests++;
    if (l15_val_o !== 1'b0) begin n_fail++; $display("FAIL load_after_ack: val=%b want 0", l15_val_o); end
  endtask

  task automatic test_store_load();
    bit ok, got; int w;
    send(5'b00001, 3'd2, 2'd0, 40'h14, 64'hDEADBEEF_00000000, ok);
    get_resp(got, w);
    n_tests++;
    if (!ok || !got || cur_out() !== expq[0]) begin
      n_fail++; $display("FAIL store_ack: ok=%b got=%b resp %h want %h", ok, got, cur_out(), expq[0]);
    end
    ack_resp();
    send(5'b00000, 3'd0, 2'd3, 40'h10, 64'h0, ok);
    get_resp(got, w);
    n_tests++;
    if (!got || cur_out() !== expq[0] || l15_data_0_o[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_readback: got=%b resp %h want %h", got, cur_out(), expq[0]);
    end
    ack_resp();
  endtask

  task automatic test_imiss_wrap();
    bit ok, got; int w;
    send(5'b10000, 3'd0, 2'd2, 40'h1000, 64'h0, ok);
    get_resp(got, w);
    n_tests++;
    if (!got || cur_out() !== expq[0] || l15_returntype_o !== 4'h1) begin
      n_fail++; $display("FAIL imiss_wrap: got=%b resp %h want %h", got, cur_out(), expq[0]);
    end
    ack_resp();
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int k = 0, vcnt = 0, first_ack = -1;
    logic [39:0] addrs [3];
    addrs[0] = 40'h30; addrs[1] = 40'h48; addrs[2] = 40'h50;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      vcnt = l15_val_o ? vcnt + 1 : 0;
      l15_req_ack_i = (vcnt >= 3);
      l15_val_i = (k < 3);
      if (k < 3) begin
        l15_rqtype_i = 5'b00000; l15_size_i = 0; l15_threadid_i = 2'(k);
        l15_address_i = addrs[k]; l15_data_i = '0;
      end
      #1;
      if (l15_val_o) begin
        n_tests++;
        if (expq.size() == 0 || cur_out() !== expq[0]) begin
          n_fail++; $display("FAIL b2b_resp: got %h queued=%0d", cur_out(), expq.size());
        end
        if (l15_req_ack_i) begin
          if (first_ack < 0) first_ack = c;
          if (expq.size() != 0) void'(expq.pop_front());
          vcnt = 0;
        end
      end
      if (k < 3 && l15_header_ack_o) begin
        model_req(5'b00000, 3'd0, 2'(k), addrs[k], 64'h0);
        acc[k] = c; k++;
      end
      if (k == 3 && expq.size() == 0) break;
    end
    @(negedge clk); l15_val_i = 0; l15_req_ack_i = 0;
    n_tests++;
    if (k != 3 || acc[0] != 0 || acc[1] != 1 || acc[2] != first_ack + 1 || expq.size() != 0) begin
      n_fail++; $display("FAIL b2b_stall: accepted=%0d at %0d,%0d,%0d first_ack=%0d left=%0d want 0,1,first_ack+1",
                         k, acc[0], acc[1], acc[2], first_ack, expq.size());
    end
  endtask

  task automatic test_unsupported();
    bit ok, seen = 0;
    send(5'b00100, 3'd0, 2'd1, 40'h20, 64'h0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL unsup_hdr_ack: ok=%b want 1", ok); end
    repeat (20) begin @(negedge clk); if (l15_val_o !== 1'b0) seen = 1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL unsup_no_resp: val_o seen=1 want 0"); end
  endtask

  task automatic test_reset_mid_store();
    bit ok, got, seen = 0; int w;
    mb_save = mb;
    send(5'b00001, 3'd3, 2'd2, 40'h20, 64'hA5A5_1234_5678_9ABC, ok);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 0;
    @(negedge clk);
    rst_ni = 1;
    mb = mb_save;
    expq.delete();
    repeat (10) begin @(negedge clk); if (l15_val_o !== 1'b0) seen = 1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL rst_mid_val: val_o seen=1 want 0"); end
    send(5'b00000, 3'd0, 2'd1, 40'h20, 64'h0, ok);
    get_resp(got, w);
    n_tests++;
    if (!got || w != LAT + 2 || cur_out() !== expq[0]) begin
      n_fail++; $display("FAIL rst_mid_load: got=%b waited=%0d resp %h want %h", got, w, cur_out(), expq[0]);
    end
    ack_resp();
  endtask

  task automatic test_random();
    bit pend = 0;
    logic [4:0] rq; logic [2:0] sz; logic [TW-1:0] tid; logic [39:0] a; logic [63:0] d;
    int r;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!pend && $urandom_range(0, 1) == 1) begin
        r  = $urandom_range(0, 9);
        rq = (r < 4) ? 5'b00000 : (r < 8) ? 5'b00001 : (r == 8) ? 5'b10000 : 5'b00110;
        sz = 3'($urandom_range(0, 3));
        tid = TW'($urandom);
        a  = {8'($urandom), 32'($urandom)};
        a[11:4] = 8'($urandom_range(0, 7));
        d  = {32'($urandom), 32'($urandom)};
        pend = 1;
      end
      l15_val_i = pend;
      l15_rqtype_i = rq; l15_size_i = sz; l15_threadid_i = tid; l15_address_i = a; l15_data_i = d;
      l15_req_ack_i = ($urandom_range(0, 1) == 1);
      #1;
      if (l15_val_o) begin
        n_tests++;
        if (expq.size() == 0 || cur_out() !== expq[0]) begin
          n_fail++; $display("FAIL rand_resp: cycle %0d got %h queued=%0d", c, cur_out(), expq.size());
        end else if (l15_req_ack_i) void'(expq.pop_front());
      end
      if (pend && l15_header_ack_o) begin model_req(rq, sz, tid, a, d); pend = 0; end
    end
    @(negedge clk); l15_val_i = 0;
    for (int c = 0; c < 200 && expq.size() != 0; c++) begin
      @(negedge clk);
      l15_req_ack_i = 1;
      if (l15_val_o) begin
        n_tests++;
        if (cur_out() !== expq[0]) begin
          n_fail++; $display("FAIL rand_drain: got %h want %h", cur_out(), expq[0]);
        end
        void'(expq.pop_front());
      end
    end
    @(negedge clk); l15_req_ack_i = 0;
    n_tests++;
    if (expq.size() != 0) begin n_fail++; $display("FAIL rand_timeout: %0d responses missing", expq.size()); end
  endtask

  initial begin
    for (int i = 0; i < NL*16; i++) mb[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mb[i] = 8'(i);
    test_reset();
    preload();
    test_load_basic();
    test_store_load();
    test_imiss_wrap();
    test_back_to_back();
    test_unsupported();
    test_reset_mid_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l15_mem_responder.md
L15_MEM_RESPONDER -- requirements
Module: l15_mem_responder

Interface
REQ-001 SHALL have parameter NumLines, default 256, meaning number of 128-bit backing-store lines (power of two).
REQ-002 SHALL have parameter RespLatency, default 2, meaning cycles from dequeue to response valid (1..15).
REQ-003 SHALL have parameter FifoDepth, default 2, meaning request queue entries (power of two).
REQ-004 SHALL have parameter TidWidth, default 2, meaning thread-id width.
REQ-005 clk_i  input  1  clock; one clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset, synchronous and active-low.
REQ-007 l15_val_i  input  1  request valid from the cache adapter.
REQ-008 l15_rqtype_i  input  5  request type: LOAD=5'b00000, STORE=5'b00001, IMISS=5'b10000.
REQ-009 l15_size_i  input  3  store size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-010 l15_threadid_i  input  TidWidth  transaction id.
REQ-011 l15_address_i  input  40  physical byte address.
REQ-012 l15_data_i  input  64  store data, big-endian byte order.
REQ-013 l15_header_ack_o  output  1  request accepted this cycle.
REQ-014 l15_val_o  output  1  response valid.
REQ-015 l15_req_ack_i  input  1  adapter consumes the response.
REQ-016 l15_returntype_o  output  4  LOAD_RET=4'h0, IFILL_RET=4'h1, ST_ACK=4'h4.
REQ-017 l15_threadid_o  output  TidWidth  echoed transaction id.
REQ-018 l15_data_0_o / l15_data_1_o  output  64 each  line words (addr[3]=0 / 1), big-endian.

Function
REQ-019 l15_header_ack_o SHALL equal l15_val_i AND queue not full, combinationally; an acked request SHALL be enqueued that edge.
REQ-020 Unsupported rqtype SHALL be acked and dropped with no response and no memory change.
REQ-021 FSM SHALL have states IDLE, WAIT, RESP; IDLE->WAIT when queue non-empty (dequeue, load counter with RespLatency-1); WAIT->RESP when counter==0; RESP->IDLE on l15_req_ack_i.
REQ-022 RespLatency==1 SHALL give l15_val_o the cycle after dequeue, RespLatency==N SHALL give it N cycles after.
REQ-023 Line index SHALL be address[4+log2(NumLines)-1:4]; upper bits ignored (wrap-around aliasing).
REQ-024 LOAD and IMISS SHALL return the full 128-bit line with each 64-bit word byte-swapped from internal little-endian storage.
REQ-025 STORE SHALL write 2^size bytes at the size-aligned offset address[2:0] (low bits ignored) of word address[3], after byte-swapping l15_data_i, then respond ST_ACK with data outputs zero.
REQ-026 Store write SHALL commit on the WAIT->RESP edge; a later load SHALL observe it.
REQ-027 l15_val_o and all response fields SHALL stay stable in RESP until l15_req_ack_i; ack outside RESP SHALL be ignored.
REQ-028 Enqueue and dequeue in the same cycle on a full queue SHALL NOT accept the new request (full decided from registered count).
REQ-029 Responses SHALL be issued strictly in request order.

Reset
REQ-030 On rst_ni low at a rising edge: FSM=IDLE, queue empty, counter 0, l15_val_o=0, returntype/threadid/data outputs 0.
REQ-031 Reset mid-transaction SHALL discard queued and in-flight requests; an uncommitted store SHALL NOT be written.
REQ-032 Backing store contents SHALL NOT be cleared by reset (initial contents undefined; benches preload).

Structure
REQ-033 rqtype/returntype encodings and size encodings SHALL live in a shared l15 package, not local to the module.
REQ-034 Request queue SHALL be one sub-module, l15_req_fifo (parameter Depth, entry = rqtype, size, tid, address, data).
REQ-035 Byte-swap SHALL be a package function reused for request and response paths.

Verification
REQ-036 Preload line 0 words {64'h0706050403020100, 64'h0F0E0D0C0B0A0908}; LOAD addr 0x0 tid 1 -> after 2 cycles val, LOAD_RET, tid 1, data_0=64'h0001020304050607.
REQ-037 STORE size 2 addr 0x14 data 64'hDEADBEEF_00000000 then LOAD addr 0x10 -> ST_ACK first, then data_0 bytes 4..7 read back DE AD BE EF in big-endian lane.
REQ-038 Three back-to-back requests with ack held low -> first two header_acked, third stalls until first response acked; responses in order.
REQ-039 IMISS addr 0x1000 with NumLines=256 -> IFILL_RET with contents of line 0 (wrap-around).
REQ-040 rst_ni low during WAIT of a STORE -> val stays 0, queue empty, subsequent LOAD returns pre-store data.
REQ-041 rqtype 5'b00100 -> header_ack 1, no l15_val_o within 20 cycles.
